// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words into instruction memory
// and holds the core in reset until the whole program has been written.
module prog_loader #(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              pc_en,
    output logic [6:0]        loaded_words,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    state_t      state;
    logic [6:0]  n_words;
    logic [6:0]  word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_reg;
    logic        xfer;

    // Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both high;
    // byte_ready is registered from the next state, so it is high throughout HDR and DATA only.
    assign xfer = byte_valid & byte_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            byte_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_rst      <= 1'b1;
            pc_en        <= 1'b0;
            loaded_words <= '0;
            err          <= 1'b0;
            n_words      <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            asm_reg      <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    state      <= S_HDR;
                    byte_ready <= 1'b1;
                end
                S_HDR: begin
                    if (xfer) begin
                        if (byte_data == 8'd0) begin
                            // Empty program: keep the current memory image and start the core.
                            state        <= S_RUN;
                            loaded_words <= '0;
                            byte_ready   <= 1'b0;
                            cpu_rst      <= 1'b0;
                            pc_en        <= 1'b1;
                        end else if (byte_data > MAX_N) begin
                            state      <= S_ERR;
                            byte_ready <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state        <= S_DATA;
                            n_words      <= byte_data[6:0];
                            byte_cnt     <= '0;
                            word_cnt     <= '0;
                            loaded_words <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        if (byte_cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {byte_data, asm_reg};
                            imem_addr    <= ADDR_W'({word_cnt, 2'b00});
                            word_cnt     <= word_cnt + 7'd1;
                            loaded_words <= word_cnt + 7'd1;
                            byte_cnt     <= '0;
                            if (word_cnt + 7'd1 == n_words) begin
                                state      <= S_RUN;
                                byte_ready <= 1'b0;
                                cpu_rst    <= 1'b0;
                                pc_en      <= 1'b1;
                            end
                        end else begin
                            case (byte_cnt)
                                2'd0:    asm_reg[7:0]   <= byte_data;
                                2'd1:    asm_reg[15:8]  <= byte_data;
                                default: asm_reg[23:16] <= byte_data;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (load_req) begin
                        state      <= S_HDR;
                        byte_ready <= 1'b1;
                        cpu_rst    <= 1'b1;
                        pc_en      <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (load_req) begin
                        state      <= S_HDR;
                        byte_ready <= 1'b1;
                        err        <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_rst    <= 1'b1;
                    pc_en      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle-exact vector table plus hand-written
// sequences for gapped streams, a full 64-word load and reset mid-word.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        load_req = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        pc_en;
    logic [6:0]  loaded_words;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int stall_cycles = 0;
    bit sb_on = 1'b0;
    logic [39:0] exp_q[$];
    logic [39:0] sb_e;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        lr;
        logic        br;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        crst;
        logic        pc;
        logic [6:0]  lw;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    prog_loader #(.MAX_WORDS(64), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .pc_en        (pc_en),
        .loaded_words (loaded_words),
        .err          (err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // scoreboard: every write pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (imem_we) begin
            wr_count++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra_write: got addr %h data %h, expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_write", {imem_addr, imem_wdata}, sb_e);
                end
            end
        end
    end

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic lr,
                                input logic br, input logic we, input logic [7:0] addr,
                                input logic [31:0] wd, input logic crst, input logic pc,
                                input logic [6:0] lw, input logic er);
        vec_t r;
        r.v = v; r.d = d; r.lr = lr; r.br = br; r.we = we; r.addr = addr;
        r.wd = wd; r.crst = crst; r.pc = pc; r.lw = lw; r.er = er;
        return r;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, ".byte_ready"}, 40'(byte_ready), 40'(0));
        chk({tag, ".imem_we"}, 40'(imem_we), 40'(0));
        chk({tag, ".imem_addr"}, 40'(imem_addr), 40'(0));
        chk({tag, ".imem_wdata"}, 40'(imem_wdata), 40'(0));
        chk({tag, ".cpu_rst"}, 40'(cpu_rst), 40'(1));
        chk({tag, ".pc_en"}, 40'(pc_en), 40'(0));
        chk({tag, ".loaded_words"}, 40'(loaded_words), 40'(0));
        chk({tag, ".err"}, 40'(err), 40'(0));
    endtask

    // driver: offer a byte until it transfers, then idle for gap cycles
    task automatic send_byte(input logic [7:0] d, input int gap);
        bit done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = d;
            if (byte_ready) begin
                @(posedge clk);
                #1;
                byte_valid = 1'b0;
                done = 1'b1;
            end else begin
                stall_cycles++;
            end
        end
        byte_valid = 1'b0;
        chk("byte_accept_timeout", 40'(done), 40'(1));
        repeat (gap) @(posedge clk);
    endtask

    task automatic pulse_load_req();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    initial begin
        logic [7:0]  prog2[9];
        logic [7:0]  a;
        logic [7:0]  wb;
        logic [31:0] word;
        int          base;

        //          v  d      lr  br we addr   wdata         crst pc lw    err
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 32'h00000000, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h02, 0, 1, 0, 8'h00, 32'h00000000, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h13, 0, 1, 0, 8'h00, 32'h00000000, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 32'h00000000, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 32'h00000000, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 1, 8'h00, 32'h00000013, 1, 0, 7'd1, 0));
        tbl.push_back(mk(1, 8'h93, 0, 1, 0, 8'h00, 32'h00000013, 1, 0, 7'd1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 32'h00000013, 1, 0, 7'd1, 0));
        tbl.push_back(mk(1, 8'h10, 0, 1, 0, 8'h00, 32'h00000013, 1, 0, 7'd1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 1, 8'h04, 32'h00100093, 0, 1, 7'd2, 0));
        tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 8'h04, 32'h00100093, 0, 1, 7'd2, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h04, 32'h00100093, 1, 0, 7'd2, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h04, 32'h00100093, 1, 0, 7'd2, 0));
        tbl.push_back(mk(1, 8'h01, 0, 1, 0, 8'h04, 32'h00100093, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h37, 0, 1, 0, 8'h04, 32'h00100093, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h12, 0, 1, 0, 8'h04, 32'h00100093, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h04, 32'h00100093, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 1, 8'h00, 32'h00001237, 0, 1, 7'd1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 32'h00001237, 1, 0, 7'd1, 0));
        tbl.push_back(mk(1, 8'h41, 0, 0, 0, 8'h00, 32'h00001237, 1, 0, 7'd1, 1));
        tbl.push_back(mk(1, 8'h05, 0, 0, 0, 8'h00, 32'h00001237, 1, 0, 7'd1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 32'h00001237, 1, 0, 7'd1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 32'h00001237, 0, 1, 7'd0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 32'h00001237, 0, 1, 7'd0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 32'h00001237, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'h01, 0, 1, 0, 8'h00, 32'h00001237, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 1, 0, 8'h00, 32'h00001237, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'hBB, 0, 1, 0, 8'h00, 32'h00001237, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'hCC, 0, 1, 0, 8'h00, 32'h00001237, 1, 0, 7'd0, 0));
        tbl.push_back(mk(1, 8'hDD, 1, 0, 1, 8'h00, 32'hDDCCBBAA, 0, 1, 7'd1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 32'hDDCCBBAA, 0, 1, 7'd1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 32'hDDCCBBAA, 1, 0, 7'd1, 0));
        tbl.push_back(mk(1, 8'h80, 0, 0, 0, 8'h00, 32'hDDCCBBAA, 1, 0, 7'd1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 32'hDDCCBBAA, 1, 0, 7'd1, 0));

        // reset block
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        #1;
        rst = 1'b1;

        // vector table: inputs before each edge, outputs checked just after it
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            byte_valid = tbl[i].v;
            byte_data  = tbl[i].d;
            load_req   = tbl[i].lr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.byte_ready", i), 40'(byte_ready), 40'(tbl[i].br));
            chk($sformatf("v%0d.imem_we", i), 40'(imem_we), 40'(tbl[i].we));
            chk($sformatf("v%0d.imem_addr", i), 40'(imem_addr), 40'(tbl[i].addr));
            chk($sformatf("v%0d.imem_wdata", i), 40'(imem_wdata), 40'(tbl[i].wd));
            chk($sformatf("v%0d.cpu_rst", i), 40'(cpu_rst), 40'(tbl[i].crst));
            chk($sformatf("v%0d.pc_en", i), 40'(pc_en), 40'(tbl[i].pc));
            chk($sformatf("v%0d.loaded_words", i), 40'(loaded_words), 40'(tbl[i].lw));
            chk($sformatf("v%0d.err", i), 40'(err), 40'(tbl[i].er));
        end
        byte_valid = 1'b0;
        load_req   = 1'b0;

        // gapped stream from HDR: same program, 3 idle cycles between bytes
        sb_on = 1'b1;
        base  = wr_count;
        prog2 = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_q.push_back({8'h00, 32'h00000013});
        exp_q.push_back({8'h04, 32'h00100093});
        for (int i = 0; i < 9; i++) send_byte(prog2[i], (i == 8) ? 0 : 3);
        chk("gap.cpu_rst", 40'(cpu_rst), 40'(0));
        chk("gap.pc_en", 40'(pc_en), 40'(1));
        chk("gap.loaded_words", 40'(loaded_words), 40'(2));
        chk("gap.byte_ready", 40'(byte_ready), 40'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("gap.write_count", 40'(wr_count - base), 40'(2));
        chk("gap.queue_empty", 40'(exp_q.size()), 40'(0));

        // full-size load: 64 words back to back, last address 0xFC
        pulse_load_req();
        chk("max.cpu_rst_reload", 40'(cpu_rst), 40'(1));
        chk("max.pc_en_reload", 40'(pc_en), 40'(0));
        send_byte(8'h40, 0);
        chk("max.err_hdr", 40'(err), 40'(0));
        stall_cycles = 0;
        for (int w = 0; w < 64; w++) begin
            wb   = 8'(w);
            a    = 8'(w * 4);
            word = {wb + 8'd1, ~wb, 8'h5A, wb};
            exp_q.push_back({a, word});
            send_word(word, 0);
        end
        chk("max.no_bubbles", 40'(stall_cycles), 40'(0));
        chk("max.cpu_rst", 40'(cpu_rst), 40'(0));
        chk("max.pc_en", 40'(pc_en), 40'(1));
        chk("max.loaded_words", 40'(loaded_words), 40'(64));
        chk("max.byte_ready", 40'(byte_ready), 40'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("max.queue_empty", 40'(exp_q.size()), 40'(0));

        // reset asserted after two bytes of word 1
        pulse_load_req();
        send_byte(8'h02, 0);
        exp_q.push_back({8'h00, 32'h11223344});
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_values("midrst");
        chk("midrst.queue_empty", 40'(exp_q.size()), 40'(0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.push_back({8'h00, 32'hCAFEF00D});
        exp_q.push_back({8'h04, 32'h00000073});
        send_byte(8'h02, 0);
        send_word(32'hCAFEF00D, 0);
        send_word(32'h00000073, 0);
        chk("midrst.cpu_rst", 40'(cpu_rst), 40'(0));
        chk("midrst.pc_en", 40'(pc_en), 40'(1));
        chk("midrst.loaded_words", 40'(loaded_words), 40'(2));
        repeat (3) @(posedge clk);
        #1;

        // report
        chk("final.queue_empty", 40'(exp_q.size()), 40'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the five-stage RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles the bytes into little-endian 32-bit words. Each word is written into the instruction memory's write port. While loading, the block holds the core in reset with `pc_en` low; when the last word is written, it releases the core and drives `pc_en` high. It sits directly upstream of the CPU top level and owns that level's `rst`/`pc_en` inputs.

## Interface
Parameters:
- `MAX_WORDS`, 64, largest accepted program size in words (the 8-bit PC spans 64 words).
- `ADDR_W`, 8, instruction-memory byte-address width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `byte_valid`  in  1  upstream byte available.
- `byte_data`  in  8  byte payload.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `load_req`  in  1  single-cycle request to reload; honoured only in RUN or ERR.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  byte address of the word being written (word-aligned).
- `imem_wdata`  out  32  word being written.
- `cpu_rst`  out  1  active-high reset to the core.
- `pc_en`  out  1  PC enable to the core.
- `loaded_words`  out  7  number of words written in the current or last load.
- `err`  out  1  header size exceeded `MAX_WORDS`.

## Operation
- **Transfer rule:** a byte transfers when `byte_valid & byte_ready` are both high at a rising clock edge.
- **States:** IDLE, HDR, DATA, RUN, ERR.
- **IDLE** (reset state):
  - `byte_ready`=0, `cpu_rst`=1, `pc_en`=0.
  - Moves unconditionally to HDR on the first clock after reset releases.
- **HDR:**
  - `byte_ready`=1.
  - The first transferred byte is N, the word count.
  - N=0 → RUN; the existing instruction memory is kept and `loaded_words`=0.
  - N>`MAX_WORDS` → ERR.
  - Otherwise, latch N, clear the byte and word counters and `loaded_words`, then go to DATA.
- **DATA:**
  - `byte_ready`=1.
  - Byte k (k=0..3) of word w is placed into bits [8k+7:8k] of the assembly register.
  - When byte 3 transfers:
    - the full word and address 4·w are registered into `imem_wdata`/`imem_addr`;
    - `imem_we` pulses on the next cycle;
    - w increments;
    - `loaded_words` becomes w+1 in the same cycle as the write.
  - After word N-1's write is launched, the state moves to RUN. `byte_ready` drops on that edge, so no further bytes are accepted.
- **RUN:**
  - `byte_ready`=0, `cpu_rst`=0, `pc_en`=1.
  - `load_req` → HDR, with `cpu_rst`=1 and `pc_en`=0 from the next cycle.
- **ERR:**
  - `byte_ready`=0, `err`=1, `cpu_rst`=1, `pc_en`=0.
  - `load_req` → HDR and clears `err`.
- **`load_req` elsewhere:** in IDLE, HDR and DATA it is ignored.
- **`cpu_rst` / `pc_en`:** registered outputs, derived from the next state, so they are glitch-free.
- **Addresses:** `imem_addr` low two bits are always 0. The maximum address is 4·(`MAX_WORDS`-1) = 8'hFC, so there is no wrap-around.

## Timing
- **Reset values:**
  - `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_rst`=1, `pc_en`=0, `loaded_words`=0, `err`=0.
  - State is IDLE.
- **Reset assertion:** asynchronous and immediate, including mid-load. Words already written stay in instruction memory; any partial word is discarded.
- **Throughput:** one byte per cycle. `byte_ready` is never deasserted inside DATA, so back-to-back bytes are accepted with zero bubbles.
- **Write latency:** the `imem_we` pulse occurs exactly 1 cycle after the 4th byte of a word transfers, and lasts exactly 1 cycle.
- **Release latency:** the state becomes RUN on the edge that accepts the final byte. `cpu_rst` falls and `pc_en` rises one cycle after that edge, coincident with the final `imem_we`. The core's first fetch (PC=0) occurs on the following edge, after the write has completed.
- **Stalled stream:** if `byte_valid` drops mid-word, the assembly register and counters hold indefinitely. There is no timeout.
- **Simultaneous events:** `load_req` in DATA together with a byte transfer → the byte is consumed normally and `load_req` is dropped.
- **RUN entry and `load_req`:** a `load_req` that arrives in the same cycle as the DATA→RUN transition is ignored.

## Test plan
- **Reset then 2-word load:**
  - Stimulus: stream 02, 13,00,00,00, 93,00,10,00 with `byte_valid` held high.
  - Required: `imem_we` at addr 00 with data 0x00000013, then at addr 04 with data 0x00100093.
  - Required: `cpu_rst` 1→0 and `pc_en` 0→1 one cycle after the last byte, with `loaded_words`=2.
- **Gapped stream:** same program with `byte_valid` low for 3 cycles between every byte → identical writes; no extra `imem_we` pulses.
- **Oversize header:**
  - Stimulus: header byte 0x41 (65).
  - Required: `err`=1, `byte_ready`=0, `pc_en`=0 on the next cycle.
  - Then a `load_req` pulse → HDR, `err`=0.
- **Zero-length load:** header 00 → RUN on the next cycle with `loaded_words`=0 and no `imem_we`.
- **Reload from RUN:**
  - Stimulus: `load_req` pulse during RUN.
  - Required: `cpu_rst`=1 and `pc_en`=0 next cycle; a following 1-word load writes addr 00 and returns to RUN.
- **Reset mid-word:**
  - Stimulus: assert `rst`=0 after 2 bytes of word 1.
  - Required: all outputs at reset values immediately.
  - After release, a full new load completes correctly, with word 0 written at addr 00.
